// File: rtl/manchester_recv.sv
// Manchester line receiver: 2-flop synchronisers, mid-bit resynchronised phase
// counter, LSB-first byte assembly with code-violation and truncation flags.
module manchester_recv #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BIT_RATE = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rxen,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int unsigned HALF = CLK_FREQ / (2 * BIT_RATE);
  localparam int unsigned PH_W = $clog2(2 * HALF);

  localparam logic [PH_W-1:0] PH_A      = PH_W'(HALF / 2);
  localparam logic [PH_W-1:0] PH_B      = PH_W'(HALF + HALF / 2);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2 * HALF - 1);
  localparam logic [PH_W-1:0] PH_WIN_LO = PH_W'(HALF - HALF / 2);
  localparam logic [PH_W-1:0] PH_WIN_HI = PH_W'(HALF + HALF / 2);
  localparam logic [PH_W-1:0] PH_RESYNC = PH_W'(HALF + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RX_BIT = 2'd1;
  localparam logic [1:0] TAIL   = 2'd2;

  logic rxd_m, rxd_s, rxd_q;
  logic rxen_m, rxen_s, rxen_q;

  logic [1:0]      state, state_nxt;
  logic [PH_W-1:0] ph, ph_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            samp_a, samp_a_nxt;
  logic [7:0]      data_nxt;
  logic            valid_nxt, err_nxt, busy_nxt;

  logic            rxen_rise_c;
  logic            rxd_edge_c;
  logic            in_win_c;
  logic            at_a_c;
  logic            at_b_c;
  logic            bit_ok_c;
  logic            byte_done_c;
  logic [7:0]      shifted_c;

  // Synchronisers run free through reset so a level already high after reset
  // release cannot masquerade as a fresh rxen rising edge.
  always_ff @(posedge clk) begin
    rxd_m  <= rxd;
    rxd_s  <= rxd_m;
    rxd_q  <= rxd_s;
    rxen_m <= rxen;
    rxen_s <= rxen_m;
    rxen_q <= rxen_s;
  end

  assign rxen_rise_c = rxen_s & ~rxen_q;
  assign rxd_edge_c  = rxd_s ^ rxd_q;
  assign in_win_c    = (ph >= PH_WIN_LO) && (ph < PH_WIN_HI);
  assign at_a_c      = (ph == PH_A);
  assign at_b_c      = (ph == PH_B);
  assign bit_ok_c    = (samp_a != rxd_s);
  assign byte_done_c = at_b_c && bit_ok_c && (idx == 3'd7);
  assign shifted_c   = {samp_a, shift[7:1]};

  // State, counters and outputs: next values
  always_comb begin
    state_nxt  = state;
    ph_nxt     = ph;
    idx_nxt    = idx;
    shift_nxt  = shift;
    samp_a_nxt = samp_a;
    data_nxt   = data;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (rxen_rise_c) begin
          ph_nxt    = '0;
          idx_nxt   = 3'd0;
          shift_nxt = 8'h00;
          state_nxt = RX_BIT;
        end
      end

      RX_BIT: begin
        ph_nxt = (ph == PH_LAST) ? '0 : ph + PH_W'(1);
        if (rxd_edge_c && in_win_c) begin
          ph_nxt = PH_RESYNC;
        end
        if (at_a_c) begin
          samp_a_nxt = rxd_s;
        end
        if (at_b_c) begin
          if (bit_ok_c) begin
            shift_nxt = shifted_c;
            if (idx == 3'd7) begin
              data_nxt  = shifted_c;
              valid_nxt = 1'b1;
              idx_nxt   = 3'd0;
            end else begin
              idx_nxt = idx + 3'd1;
            end
          end else if (samp_a && (idx == 3'd0)) begin
            state_nxt = TAIL;
          end else begin
            err_nxt   = 1'b1;
            idx_nxt   = 3'd0;
            shift_nxt = 8'h00;
            state_nxt = TAIL;
          end
        end
        // Enable dropped mid-frame; a byte completing this clock still wins.
        if (!rxen_s) begin
          state_nxt = IDLE;
          if (!byte_done_c) begin
            err_nxt   = (idx != 3'd0) || (ph != '0);
            idx_nxt   = 3'd0;
            shift_nxt = 8'h00;
          end
        end
      end

      TAIL: begin
        if (!rxen_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      ph     <= '0;
      idx    <= 3'd0;
      shift  <= 8'h00;
      samp_a <= 1'b0;
      data   <= 8'h00;
      valid  <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ph     <= ph_nxt;
      idx    <= idx_nxt;
      shift  <= shift_nxt;
      samp_a <= samp_a_nxt;
      data   <= data_nxt;
      valid  <= valid_nxt;
      err    <= err_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_manchester_recv.sv
// Directed bench for manchester_recv: encodes frames on the line and checks
// every valid/err pulse and the held data against an event-queue model.
module tb_manchester_recv;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BIT_RATE = 20_000;
  localparam int H   = int'(CLK_FREQ / (2 * BIT_RATE));
  localparam int LAT = 3;
  localparam int TOL = 2;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       rxd  = 1'b1;
  logic       rxen = 1'b0;
  logic [7:0] data;
  logic       valid, err, busy;

  manchester_recv #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rxen(rxen),
    .data(data), .valid(valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_valid;
    logic [7:0] b;
    int         due;
  } ev_t;

  ev_t        evq[$];
  int         errors = 0;
  int         checks = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         last_v = -1;
  int         prev_v = -1;
  logic [7:0] model_data = 8'h00;
  bit         cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic push_ev(input bit is_valid, input logic [7:0] b, input int due);
    ev_t e;
    e.is_valid = is_valid;
    e.b        = b;
    e.due      = due;
    evq.push_back(e);
  endtask

  // Sends nbits of b LSB first; bad_bit gets a low/low (same-level) cell,
  // rst_bit gets a one-clock reset pulse in its first half.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int hl,
                           input int bad_bit, input int rst_bit);
    logic v;
    bit   expect_byte;
    expect_byte = (bad_bit < 0) && (rst_bit < 0) && (nbits == 8);
    for (int i = 0; i < nbits; i++) begin
      v = b[i];
      if (i == bad_bit) push_ev(1'b0, 8'h00, cyc + H + H / 2 + LAT);
      rxd = v;
      if (i == rst_bit) begin
        repeat (hl / 2) @(negedge clk);
        rst = 1'b0;
        model_data = 8'h00;
        @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        repeat (hl - hl / 2 - 1) @(negedge clk);
      end else begin
        repeat (hl) @(negedge clk);
      end
      rxd = (i == bad_bit) ? v : ~v;
      if (expect_byte && i == 7) push_ev(1'b1, b, cyc + H / 2 + LAT);
      repeat (hl) @(negedge clk);
    end
  endtask

  task automatic idle_end(input int hl);
    rxd = 1'b1;
    repeat (4 * hl) @(negedge clk);
    rxen = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Compare process: every pulse must match the next queued event in kind,
  // time window and byte; between pulses data must hold the model's byte.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en && rst) begin
        if (valid || err) begin
          if (valid) begin
            n_valid++;
            prev_v = last_v;
            last_v = cyc;
          end
          if (err) n_err++;
          if (valid && err) fail_now("valid_err_same", "valid and err both high");
          if (evq.size() == 0) begin
            fail_now("unexpected_pulse", valid ? "valid with no byte due" : "err with no fault sent");
          end else begin
            e = evq.pop_front();
            check("pulse_kind_valid", 32'(valid), 32'(e.is_valid));
            check_rng("pulse_time", cyc, e.due - TOL, e.due + TOL);
            if (e.is_valid) begin
              check("data_on_valid", 32'(data), 32'(e.b));
              model_data = e.b;
            end
          end
        end else begin
          check("data_hold", 32'(data), 32'(model_data));
          if (evq.size() > 0 && cyc > evq[0].due + TOL) begin
            e = evq.pop_front();
            fail_now(e.is_valid ? "missing_valid" : "missing_err", "expected pulse never seen");
          end
        end
      end
    end
  end

  initial begin
    int v0, e0;
    repeat (4) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    cmp_en = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte 0xA5
    v0 = n_valid; e0 = n_err;
    rxen = 1'b1;
    send_bits(8'hA5, 8, H, -1, -1);
    idle_end(H);
    check("a5_valid_count", 32'(n_valid - v0), 32'd1);
    check("a5_err_count", 32'(n_err - e0), 32'd0);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_busy_after", 32'(busy), 32'h0);

    // Back-to-back 0x3C, 0xFF
    v0 = n_valid; e0 = n_err;
    rxen = 1'b1;
    send_bits(8'h3C, 8, H, -1, -1);
    send_bits(8'hFF, 8, H, -1, -1);
    idle_end(H);
    check("b2b_valid_count", 32'(n_valid - v0), 32'd2);
    check("b2b_err_count", 32'(n_err - e0), 32'd0);
    check("b2b_data", 32'(data), 32'hFF);
    check_rng("b2b_spacing", last_v - prev_v, 16 * H - 2, 16 * H + 2);

    // Code violation on bit 4 of 0x00, then 0x81
    v0 = n_valid; e0 = n_err;
    rxen = 1'b1;
    send_bits(8'h00, 8, H, 4, -1);
    rxd = 1'b1;
    repeat (4 * H) @(negedge clk);
    check("viol_busy_tail", 32'(busy), 32'h1);
    rxen = 1'b0;
    repeat (4) @(negedge clk);
    check("viol_busy_after", 32'(busy), 32'h0);
    repeat (6) @(negedge clk);
    check("viol_err_count", 32'(n_err - e0), 32'd1);
    check("viol_valid_count", 32'(n_valid - v0), 32'd0);
    check("viol_data_kept", 32'(data), 32'hFF);
    v0 = n_valid; e0 = n_err;
    rxen = 1'b1;
    send_bits(8'h81, 8, H, -1, -1);
    idle_end(H);
    check("x81_valid_count", 32'(n_valid - v0), 32'd1);
    check("x81_data", 32'(data), 32'h81);

    // Truncation after 3 bits of 0x55
    v0 = n_valid; e0 = n_err;
    rxen = 1'b1;
    send_bits(8'h55, 3, H, -1, -1);
    rxen = 1'b0;
    rxd = 1'b1;
    push_ev(1'b0, 8'h00, cyc + LAT);
    repeat (4) @(negedge clk);
    check("trunc_busy", 32'(busy), 32'h0);
    repeat (10) @(negedge clk);
    check("trunc_err_count", 32'(n_err - e0), 32'd1);
    check("trunc_valid_count", 32'(n_valid - v0), 32'd0);

    // +4% slow transmitter: 0x96, 0x69
    v0 = n_valid; e0 = n_err;
    rxen = 1'b1;
    send_bits(8'h96, 8, H + 1, -1, -1);
    send_bits(8'h69, 8, H + 1, -1, -1);
    idle_end(H + 1);
    check("drift_valid_count", 32'(n_valid - v0), 32'd2);
    check("drift_err_count", 32'(n_err - e0), 32'd0);
    check("drift_data", 32'(data), 32'h69);

    // Reset during bit 5, rest of frame ignored, then 0xC3
    v0 = n_valid; e0 = n_err;
    rxen = 1'b1;
    send_bits(8'h5A, 8, H, -1, 5);
    check("rst_busy_rest", 32'(busy), 32'h0);
    idle_end(H);
    check("rst_valid_count", 32'(n_valid - v0), 32'd0);
    check("rst_err_count", 32'(n_err - e0), 32'd0);
    check("rst_data_after", 32'(data), 32'h00);
    v0 = n_valid;
    rxen = 1'b1;
    send_bits(8'hC3, 8, H, -1, -1);
    idle_end(H);
    check("xc3_valid_count", 32'(n_valid - v0), 32'd1);
    check("xc3_data", 32'(data), 32'hC3);

    repeat (50) @(negedge clk);
    while (evq.size() > 0) begin
      void'(evq.pop_front());
      fail_now("missing_pulse", "event still queued at end");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
